// File: rtl/feedback_pkg.sv
// rtl/feedback_pkg.sv - shared state encoding, default latencies and width helpers
package feedback_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int DEF_LAT1        = 2;
    localparam int DEF_LAT2        = 3;
    localparam int DEF_INIT_TOKENS = 1;
    localparam int DEF_OUT_DEPTH   = 4;

    // Bits needed to hold a count in the range 0..max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/feedback_loop_sched_token_delay_line.sv
// rtl/feedback_loop_sched_token_delay_line.sv - valid-bit shift register with tail and occupancy count
module token_delay_line
    import feedback_pkg::*;
#(
    parameter int LEN = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_i,
    output logic                      tail_o,
    output logic [cnt_width(LEN)-1:0] count_o
);

    localparam int CW = cnt_width(LEN);

    logic [LEN-1:0] pipe_q;
    logic [LEN-1:0] pipe_d;

    generate
        if (LEN == 1) begin : g_single
            assign pipe_d = in_i;
        end else begin : g_multi
            assign pipe_d = {pipe_q[LEN-2:0], in_i};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tail_o = pipe_q[LEN-1];

    always_comb begin
        count_o = '0;
        for (int i = 0; i < LEN; i++) begin
            count_o = count_o + CW'(pipe_q[i]);
        end
    end

endmodule

// File: rtl/feedback_loop_sched.sv
// rtl/feedback_loop_sched.sv - token-accounting scheduler for the two-kernel feedback loop
module feedback_loop_sched
    import feedback_pkg::*;
#(
    parameter int LAT1        = DEF_LAT1,
    parameter int LAT2        = DEF_LAT2,
    parameter int INIT_TOKENS = DEF_INIT_TOKENS,
    parameter int OUT_DEPTH   = DEF_OUT_DEPTH
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic                            flush_i,
    input  logic                            x_valid_i,
    output logic                            x_ready_o,
    output logic                            fire1_o,
    output logic                            fire2_o,
    output logic                            w_valid_o,
    input  logic                            w_pop_i,
    output logic                            busy_o,
    output logic [cnt_width(LAT1+LAT2)-1:0] inflight_o
);

    localparam int YW  = cnt_width(INIT_TOKENS);
    localparam int WW  = cnt_width(OUT_DEPTH);
    localparam int IW  = cnt_width(LAT1 + LAT2);
    localparam int C1W = cnt_width(LAT1);
    localparam int C2W = cnt_width(LAT2);

    state_e          state_q;
    logic [YW-1:0]   y_cnt_q;
    logic [YW-1:0]   y_cnt_d;
    logic [WW-1:0]   w_cred_q;
    logic [WW-1:0]   w_cred_d;
    logic            busy_q;
    logic            fire1;
    logic            fire2;
    logic            w_valid;
    logic            y_avail;
    logic            pop_ok;
    logic [C1W-1:0]  cnt1;
    logic [C2W-1:0]  cnt2;
    logic [IW-1:0]   inflight;

    // A y token returning this cycle may be reused at once, so the loop sustains II=LAT1+LAT2
    assign y_avail = (y_cnt_q != '0) | w_valid;
    assign fire1   = (state_q == S_RUN) & x_valid_i & y_avail & (w_cred_q != '0);
    assign pop_ok  = w_pop_i & (w_cred_q != WW'(OUT_DEPTH));

    token_delay_line #(.LEN(LAT1)) u_pipe1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .in_i    (fire1),
        .tail_o  (fire2),
        .count_o (cnt1)
    );

    token_delay_line #(.LEN(LAT2)) u_pipe2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .in_i    (fire2),
        .tail_o  (w_valid),
        .count_o (cnt2)
    );

    assign inflight = IW'(cnt1) + IW'(cnt2);

    always_comb begin
        y_cnt_d = y_cnt_q;
        if (w_valid && !fire1) begin
            y_cnt_d = y_cnt_q + YW'(1);
        end else if (fire1 && !w_valid) begin
            y_cnt_d = y_cnt_q - YW'(1);
        end
    end

    always_comb begin
        w_cred_d = w_cred_q;
        if (fire1 && !pop_ok) begin
            w_cred_d = w_cred_q - WW'(1);
        end else if (pop_ok && !fire1) begin
            w_cred_d = w_cred_q + WW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            y_cnt_q  <= '0;
            w_cred_q <= WW'(OUT_DEPTH);
            busy_q   <= 1'b0;
        end else begin
            y_cnt_q  <= y_cnt_d;
            w_cred_q <= w_cred_d;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        y_cnt_q <= YW'(INIT_TOKENS);
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (inflight == '0) begin
                        state_q <= S_IDLE;
                        y_cnt_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x_ready_o  = fire1;
    assign fire1_o    = fire1;
    assign fire2_o    = fire2;
    assign w_valid_o  = w_valid;
    assign busy_o     = busy_q;
    assign inflight_o = inflight;

    a_y_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_valid && !fire1 && (y_cnt_q >= YW'(INIT_TOKENS))));

    a_no_pop_at_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_pop_i && (w_cred_q == WW'(OUT_DEPTH))));

endmodule
